// File: rtl/mac_col_pkg.sv
// Shared definitions for the mac_col_acc output column: instruction bit
// positions, the column FSM states and a width helper for the load counter.
package mac_col_pkg;

  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;
  localparam int INST_ACC  = 2;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Width of the load-beat counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_col_acc_dot.sv
// mac_dot: combinational PR-lane signed dot product. Every lane product is
// kept at full 2*BW precision and the sum gets enough guard bits that it
// cannot overflow, before being resized to BW_PSUM.
module mac_dot #(
  parameter int BW      = 8,
  parameter int PR      = 8,
  parameter int BW_PSUM = 2*BW+6
) (
  input  logic [PR*BW-1:0]         i_a,
  input  logic [PR*BW-1:0]         i_b,
  output logic signed [BW_PSUM-1:0] o_dot
);

  localparam int SUM_W = 2*BW + $clog2(PR) + 1;

  logic signed [2*BW-1:0] w_prod [PR];
  logic signed [SUM_W-1:0] w_sum;

  genvar gi;
  generate
    for (gi = 0; gi < PR; gi++) begin : g_lane
      assign w_prod[gi] = $signed(i_a[gi*BW +: BW]) * $signed(i_b[gi*BW +: BW]);
    end
  endgenerate

  // Adder tree over all lane products, sign-extended into the guard width.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < PR; i++) begin
      w_sum = w_sum + SUM_W'(w_prod[i]);
    end
  end

  assign o_dot = BW_PSUM'(w_sum);

endmodule

// File: rtl/mac_col_acc.sv
// mac_col_acc: one output column of the 1D vector NPU array. Captures a key
// from the skewed load stream, then accumulates dot products of streamed
// queries against it and emits a registered, strobed result per group.
// Optional feature macro: MAC_COL_SAT_EN (clamp result to BW_PSUM, raise sat_flag).
module mac_col_acc
  import mac_col_pkg::*;
#(
  parameter int BW        = 8,
  parameter int PR        = 8,
  parameter int BW_PSUM   = 2*BW+6,
  parameter int ACC_EXT   = 4,
  parameter int NUM_COLS  = 8,
  parameter int COL_ID    = 0,
  parameter int LOAD_SKEW = NUM_COLS-1-COL_ID
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PR*BW-1:0]   q_in,
  input  logic [2:0]         i_inst,
  output logic [PR*BW-1:0]   q_out,
  output logic [2:0]         o_inst,
  output logic [BW_PSUM-1:0] out,
  output logic               out_valid,
  output logic               key_loaded,
  output logic               sat_flag
);

  localparam int ACC_W = BW_PSUM + ACC_EXT;
  localparam int CNT_W = cnt_width(NUM_COLS);

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [PR*BW-1:0]         r_key;
  logic [PR*BW-1:0]         r_query;
  logic [2:0]               r_inst;
  logic signed [ACC_W-1:0]  r_acc;
  logic [BW_PSUM-1:0]       r_out;
  logic                     r_out_valid;

  logic                     w_load_beat;
  logic                     w_exec_beat;
  logic                     w_rearm;
  logic                     w_stage_exec;
  logic                     w_stage_close;
  logic signed [BW_PSUM-1:0] w_dot;
  logic signed [ACC_W-1:0]  w_psum_ext;
  logic signed [ACC_W-1:0]  w_result;
  logic [BW_PSUM-1:0]       w_out_next;

  // Load wins over execute when both bits are set.
  assign w_load_beat = i_inst[INST_LOAD];
  assign w_exec_beat = i_inst[INST_EXEC] & ~i_inst[INST_LOAD];
  assign w_rearm     = (r_state == ST_RUN) & w_load_beat;

  // The compute stage is the registered beat; ARM-state beats never compute.
  assign w_stage_exec  = r_inst[INST_EXEC] & ~r_inst[INST_LOAD] &
                         ((r_state == ST_READY) | (r_state == ST_RUN));
  assign w_stage_close = w_stage_exec & ~r_inst[INST_ACC];

  assign key_loaded = (r_state == ST_READY) | (r_state == ST_RUN);
  assign q_out      = r_query;
  assign o_inst     = r_inst;
  assign out        = r_out;
  assign out_valid  = r_out_valid;

  mac_dot #(
    .BW      (BW),
    .PR      (PR),
    .BW_PSUM (BW_PSUM)
  ) u_dot (
    .i_a   (r_query),
    .i_b   (r_key),
    .o_dot (w_dot)
  );

  assign w_psum_ext = ACC_W'(w_dot);
  assign w_result   = r_acc + w_psum_ext;

`ifdef MAC_COL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_EXT+1){1'b0}}, {(BW_PSUM-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_EXT+1){1'b1}}, {(BW_PSUM-1){1'b0}}};

  logic w_sat_hit;
  logic r_sat;

  // Clamp the wide result into the output range and note when it happened.
  always_comb begin
    w_sat_hit  = 1'b0;
    w_out_next = w_result[BW_PSUM-1:0];
    if (w_result > SAT_MAX) begin
      w_sat_hit  = 1'b1;
      w_out_next = SAT_MAX[BW_PSUM-1:0];
    end else if (w_result < SAT_MIN) begin
      w_sat_hit  = 1'b1;
      w_out_next = SAT_MIN[BW_PSUM-1:0];
    end
  end

  // Saturation flag is a pulse aligned with the result strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sat <= 1'b0;
    end else begin
      r_sat <= w_stage_close & w_sat_hit;
    end
  end

  assign sat_flag = r_sat;
`else
  assign w_out_next = w_result[BW_PSUM-1:0];
  assign sat_flag   = 1'b0;
`endif

  // Forward instruction every cycle; forward query only on load/execute beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst  <= '0;
      r_query <= '0;
    end else begin
      r_inst <= i_inst;
      if (w_load_beat | w_exec_beat) begin
        r_query <= q_in;
      end
    end
  end

  // Key capture FSM: count skewed load beats, capture ours, re-arm from RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ARM;
      r_cnt   <= '0;
      r_key   <= '0;
    end else begin
      case (r_state)
        ST_ARM: begin
          if (w_load_beat) begin
            if (r_cnt == CNT_W'(LOAD_SKEW)) begin
              r_key   <= q_in;
              r_cnt   <= '0;
              r_state <= ST_READY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (w_exec_beat) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A re-arming load beat is itself beat index 0 of the new stream.
          if (w_load_beat) begin
            if (LOAD_SKEW == 0) begin
              r_key   <= q_in;
              r_cnt   <= '0;
              r_state <= ST_READY;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= ST_ARM;
            end
          end
        end
        default: begin
          r_state <= ST_ARM;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Group accumulator; a re-arm discards any open group, even one closing now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_rearm) begin
      r_acc <= '0;
    end else if (w_stage_exec) begin
      r_acc <= r_inst[INST_ACC] ? w_result : '0;
    end
  end

  // Registered result and one-cycle strobe per closed group; out holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_stage_close;
      if (w_stage_close) begin
        r_out <= w_out_next;
      end
    end
  end

endmodule

// File: tb/tb_mac_col_acc.sv
// Directed, table-driven bench for mac_col_acc (COL_ID=5, LOAD_SKEW=2).
module tb_mac_col_acc;

  localparam int BW        = 8;
  localparam int PR        = 8;
  localparam int BW_PSUM   = 2*BW+6;
  localparam int ACC_EXT   = 4;
  localparam int NUM_COLS  = 8;
  localparam int COL_ID    = 5;
  localparam int LOAD_SKEW = 2;

  localparam logic [2:0] I_N  = 3'b000;
  localparam logic [2:0] I_L  = 3'b001;
  localparam logic [2:0] I_E  = 3'b010;
  localparam logic [2:0] I_EA = 3'b110;

`ifdef MAC_COL_SAT_EN
  localparam int   SAT_OUT  = -2097152;
  localparam logic SAT_FLAG = 1'b1;
`else
  localparam int   SAT_OUT  = 1983488;
  localparam logic SAT_FLAG = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [PR*BW-1:0]   q_in;
  logic [2:0]         i_inst;
  logic [PR*BW-1:0]   q_out;
  logic [2:0]         o_inst;
  logic [BW_PSUM-1:0] out;
  logic               out_valid;
  logic               key_loaded;
  logic               sat_flag;

  mac_col_acc #(
    .BW        (BW),
    .PR        (PR),
    .BW_PSUM   (BW_PSUM),
    .ACC_EXT   (ACC_EXT),
    .NUM_COLS  (NUM_COLS),
    .COL_ID    (COL_ID),
    .LOAD_SKEW (LOAD_SKEW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .i_inst     (i_inst),
    .q_out      (q_out),
    .o_inst     (o_inst),
    .out        (out),
    .out_valid  (out_valid),
    .key_loaded (key_loaded),
    .sat_flag   (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        inst;
    logic signed [7:0] qv;
    logic              exp_valid;
    int                exp_out;
    logic              exp_kl;
    logic              exp_sat;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic add(input logic [2:0] inst, input logic signed [7:0] qv,
                     input logic v, input int o, input logic kl, input logic s);
    vec_t r;
    r.inst = inst; r.qv = qv; r.exp_valid = v; r.exp_out = o; r.exp_kl = kl; r.exp_sat = s;
    vecs.push_back(r);
  endtask

  // One hand-driven cycle: drive on the falling edge, sample 1 ns after rise.
  task automatic step(input logic [2:0] inst, input logic signed [7:0] qv);
    @(negedge clk);
    i_inst = inst;
    q_in   = {PR{qv}};
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q_hold;
    int         held_out;

    reset  = 1'b1;
    i_inst = '0;
    q_in   = '0;
    #1;
    chk("reset out", $signed(out), 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset sat_flag", sat_flag, 0);
    chk("reset q_out", q_out, 0);
    chk("reset o_inst", o_inst, 0);
    chk("reset key_loaded", key_loaded, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: key capture on the third load beat; a fourth load is ignored.
    add(I_L, 8'sd1, 0, 0, 0, 0);
    add(I_L, 8'sd2, 0, 0, 0, 0);
    add(I_L, 8'sd3, 0, 0, 1, 0);
    add(I_L, 8'sd9, 0, 0, 1, 0);
    // Test 2: single execute, 8 lanes * 2 * 3 = 48.
    add(I_E, 8'sd2, 0, 0, 1, 0);
    add(I_N, 8'sd0, 1, 48, 1, 0);
    add(I_N, 8'sd0, 0, 0, 1, 0);
    // Test 3: three-beat group, 3 * 8 * 1 * 3 = 72.
    add(I_EA, 8'sd1, 0, 0, 1, 0);
    add(I_EA, 8'sd1, 0, 0, 1, 0);
    add(I_E,  8'sd1, 0, 0, 1, 0);
    add(I_N,  8'sd0, 1, 72, 1, 0);
    add(I_N,  8'sd0, 0, 0, 1, 0);
    // Test 4: re-arm to key 127, then 17 beats of -128.
    add(I_L, 8'sd0, 0, 0, 0, 0);
    add(I_L, 8'sd0, 0, 0, 0, 0);
    add(I_L, 8'sd127, 0, 0, 1, 0);
    for (int k = 0; k < 16; k++) add(I_EA, -8'sd128, 0, 0, 1, 0);
    add(I_E, -8'sd128, 0, 0, 1, 0);
    add(I_N, 8'sd0, 1, SAT_OUT, 1, SAT_FLAG);
    add(I_N, 8'sd0, 0, 0, 1, 0);
    // Test 5: re-arm mid-group, execute during ARM, new key 4, 8 * 4 = 32.
    add(I_EA, 8'sd1, 0, 0, 1, 0);
    add(I_EA, 8'sd1, 0, 0, 1, 0);
    add(I_L,  8'sd4, 0, 0, 0, 0);
    add(I_E,  8'sd7, 0, 0, 0, 0);
    add(I_L,  8'sd4, 0, 0, 0, 0);
    add(I_L,  8'sd4, 0, 0, 1, 0);
    add(I_E,  8'sd1, 0, 0, 1, 0);
    add(I_N,  8'sd0, 1, 32, 1, 0);
    add(I_N,  8'sd0, 0, 0, 1, 0);

    q_hold   = '0;
    held_out = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      logic [63:0] exp_q;
      step(vecs[i].inst, vecs[i].qv);
      if (vecs[i].inst[0] | vecs[i].inst[1]) q_hold = vecs[i].qv;
      if (vecs[i].exp_valid) held_out = vecs[i].exp_out;
      exp_q = {PR{q_hold}};
      chk($sformatf("row%0d o_inst", i), o_inst, vecs[i].inst);
      chk($sformatf("row%0d q_out", i), q_out, exp_q);
      chk($sformatf("row%0d out_valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("row%0d out", i), $signed(out), held_out);
      chk($sformatf("row%0d key_loaded", i), key_loaded, vecs[i].exp_kl);
      chk($sformatf("row%0d sat_flag", i), sat_flag, vecs[i].exp_sat);
    end

    // Test 6: async reset while a strobe is showing and a group is open.
    step(I_E, 8'sd1);
    step(I_EA, 8'sd1);
    chk("pre-reset out_valid", out_valid, 1);
    chk("pre-reset out", $signed(out), 32);
    #2;
    reset  = 1'b1;
    i_inst = I_N;
    #1;
    chk("async key_loaded", key_loaded, 0);
    chk("async out_valid", out_valid, 0);
    chk("async out", $signed(out), 0);
    chk("async o_inst", o_inst, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(I_E, 8'sd1);
      chk($sformatf("post-reset exec%0d out_valid", k), out_valid, 0);
      chk($sformatf("post-reset exec%0d key_loaded", k), key_loaded, 0);
    end
    step(I_N, 8'sd0);
    chk("post-reset drain out_valid", out_valid, 0);
    step(I_L, 8'sd5);
    step(I_L, 8'sd5);
    chk("reload beat1 key_loaded", key_loaded, 0);
    step(I_L, 8'sd5);
    chk("reload beat2 key_loaded", key_loaded, 1);
    step(I_E, 8'sd2);
    chk("reload exec out_valid", out_valid, 0);
    step(I_N, 8'sd0);
    chk("reload result out_valid", out_valid, 1);
    chk("reload result out", $signed(out), 80);
    step(I_N, 8'sd0);
    chk("reload strobe width", out_valid, 0);
    chk("reload out hold", $signed(out), 80);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
